// File: rtl/dmem_arbiter.sv
// Shares one data-memory port among NUM_REQ requesters, with one transaction in flight at a time.
// Arbitration is fixed priority (lowest index wins); define DMEM_ARB_RR_EN for round-robin.
module dmem_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0][31:0]  req_addr,
  input  logic [NUM_REQ-1:0][3:0]   req_rmask,
  input  logic [NUM_REQ-1:0][3:0]   req_wmask,
  input  logic [NUM_REQ-1:0][31:0]  req_wdata,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [31:0]               resp_rdata,
  output logic [31:0]               dmem_addr,
  output logic [3:0]                dmem_rmask,
  output logic [3:0]                dmem_wmask,
  output logic [31:0]               dmem_wdata,
  input  logic [31:0]               dmem_rdata,
  input  logic                      dmem_resp
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef logic [PTR_W-1:0] idx_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_NOOP
  } state_e;

  state_e      state_q, state_d;
  idx_t        owner_q, owner_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  rmask_q, rmask_d;
  logic [3:0]  wmask_q, wmask_d;

`ifdef DMEM_ARB_RR_EN
  idx_t        rr_ptr_q, rr_ptr_d;
`endif

  idx_t        winner;
  logic        found;
  int          pos;

  // Scan from the search start (rr pointer or 0) and take the first valid requester.
  always_comb begin
    // NOTE: every comb output gets a default before any branch so no latch is inferred.
    winner = '0;
    found  = 1'b0;
    pos    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
`ifdef DMEM_ARB_RR_EN
      pos = int'(rr_ptr_q) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
`else
      pos = k;
`endif
      if (!found && req_valid[idx_t'(pos)]) begin
        found  = 1'b1;
        winner = idx_t'(pos);
      end
    end
  end

  // Next-state and latch logic.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rmask_d = rmask_q;
    wmask_d = wmask_q;
`ifdef DMEM_ARB_RR_EN
    rr_ptr_d = rr_ptr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (found) begin
          owner_d = winner;
          addr_d  = req_addr[winner];
          wdata_d = req_wdata[winner];
          wmask_d = req_wmask[winner];
          // A request with both masks set is treated as a store.
          rmask_d = (|req_wmask[winner]) ? 4'h0 : req_rmask[winner];
          state_d = (|req_wmask[winner] || |req_rmask[winner]) ? S_ISSUE : S_NOOP;
`ifdef DMEM_ARB_RR_EN
          rr_ptr_d = (winner == idx_t'(NUM_REQ - 1)) ? '0 : winner + idx_t'(1);
`endif
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (dmem_resp) state_d = S_IDLE;
      S_NOOP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are forced quiet while reset is asserted so a dropped transaction never completes.
  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    resp_rdata = '0;
    dmem_rmask = '0;
    dmem_wmask = '0;
    if (!rst) begin
      case (state_q)
        S_IDLE: req_ready[winner] = found;
        S_ISSUE: begin
          dmem_rmask = rmask_q;
          dmem_wmask = wmask_q;
        end
        S_WAIT: begin
          if (dmem_resp) begin
            resp_valid[owner_q] = 1'b1;
            resp_rdata          = (|rmask_q) ? dmem_rdata : 32'h0;
          end
        end
        S_NOOP: resp_valid[owner_q] = 1'b1;
        default: ;
      endcase
    end
  end

  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      owner_q  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rmask_q  <= '0;
      wmask_q  <= '0;
`ifdef DMEM_ARB_RR_EN
      rr_ptr_q <= '0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      state_q  <= state_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rmask_q  <= rmask_d;
      wmask_q  <= wmask_d;
`ifdef DMEM_ARB_RR_EN
      rr_ptr_q <= rr_ptr_d;
`endif
    end
  end

endmodule
